// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame parameters.
package uart_pkg;

    localparam int unsigned DBIT_DEF    = 8;
    localparam int unsigned OVS_DEF     = 16;
    localparam int unsigned SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    // Larger of two unsigned values, used to size shared counters.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, paced by a 16x oversampling tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = DBIT_DEF,
    parameter int unsigned OVS     = OVS_DEF,
    parameter int unsigned SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            busy,
    output logic            tx_done_tick
);

    localparam int unsigned S_MAX = max_u(OVS, SB_TICK);
    localparam int unsigned SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state and datapath: counters only move on s_tick outside IDLE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    shreg_d = din;
                    s_d     = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(OVS - 1)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                        tx_d    = shreg_q[0];
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(OVS - 1)) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + NW'(1);
                            tx_d = shreg_d[0];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d     = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: logs the line every cycle, then checks frame windows.
module tb_uart_tx;

    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx;
    logic       busy;
    logic       tx_done_tick;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int tick_per = 0;
    int tick_ph = 0;

    logic log_tx   [LOGN];
    logic log_busy [LOGN];
    logic log_done [LOGN];

    uart_tx dut (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .busy         (busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: sample outputs just after the edge, then set s_tick for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (cyc < LOGN) begin
            log_tx[cyc]   = tx;
            log_busy[cyc] = busy;
            log_done[cyc] = tx_done_tick;
        end
        cyc++;
        if (tick_per == 0) begin
            s_tick = 1'b0;
        end else begin
            tick_ph = (tick_ph + 1 >= tick_per) ? 0 : tick_ph + 1;
            s_tick  = (tick_ph == 0);
        end
    endtask

    task automatic run_to(input int idx);
        while (cyc <= idx) step();
    endtask

    // Wait for a tick-aligned edge, then request a frame for one cycle.
    task automatic launch(input logic [7:0] d, output int start);
        din = d;
        for (int i = 0; i < 16 && s_tick !== 1'b1; i++) step();
        chk("tick_align", int'(s_tick), 1);
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        start = cyc - 1;
    endtask

    // bits[j] is the line level expected during bit slot j (start, 8 data, stop).
    task automatic check_frame(input string tag, input int start, input logic [9:0] bits,
                               input int per);
        int len;
        int cnt;
        len = 16 * per;
        for (int j = 0; j < 10; j++) begin
            cnt = 0;
            for (int i = start + j * len; i < start + (j + 1) * len; i++)
                if (log_tx[i] === bits[j]) cnt++;
            chk($sformatf("%s_slot%0d", tag, j), cnt, len);
        end
        chk({tag, "_done_at_end"}, int'(log_done[start + 160 * per]), 1);
        chk({tag, "_busy_last"}, int'(log_busy[start + 160 * per - 1]), 1);
    endtask

    task automatic tally(input int from, input int to, output int n_busy, output int n_done,
                         output int n_hi);
        n_busy = 0;
        n_done = 0;
        n_hi   = 0;
        for (int i = from; i < to; i++) begin
            if (log_busy[i] === 1'b1) n_busy++;
            if (log_done[i] === 1'b1) n_done++;
            if (log_tx[i] === 1'b1) n_hi++;
        end
    endtask

    initial begin
        int s, s2, nb, nd, nh;
        rst      = 1'b1;
        tx_start = 1'b0;
        din      = 8'h00;
        s_tick   = 1'b0;

        // Reset held three cycles with s_tick toggling.
        tick_per = 2;
        repeat (3) step();
        chk("rst_tx", int'(log_tx[cyc - 1]), 1);
        chk("rst_busy", int'(log_busy[cyc - 1]), 0);
        chk("rst_done", int'(log_done[cyc - 1]), 0);
        rst = 1'b0;
        s = cyc;
        repeat (20) step();
        tally(s, cyc, nb, nd, nh);
        chk("idle_busy", nb, 0);
        chk("idle_done", nd, 0);
        chk("idle_tx_hi", nh, 20);

        // 0xA5, tick every cycle.
        tick_per = 1;
        launch(8'hA5, s);
        run_to(s + 170);
        check_frame("a5", s, 10'b1_1010_0101_0, 1);
        tally(s, s + 171, nb, nd, nh);
        chk("a5_busy_len", nb, 160);
        chk("a5_done_cnt", nd, 1);

        // 0x3C, tick every 5 clocks.
        tick_per = 5;
        tick_ph  = 0;
        launch(8'h3C, s);
        run_to(s + 820);
        check_frame("3c", s, 10'b1_0011_1100_0, 5);
        tally(s, s + 821, nb, nd, nh);
        chk("3c_busy_len", nb, 800);
        chk("3c_done_cnt", nd, 1);

        // 0x00 with a new request and din=0xFF mid-frame: both ignored.
        tick_per = 1;
        launch(8'h00, s);
        run_to(s + 49);
        din      = 8'hFF;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        run_to(s + 300);
        check_frame("00", s, 10'b1_0000_0000_0, 1);
        tally(s, s + 301, nb, nd, nh);
        chk("00_busy_len", nb, 160);
        chk("00_done_cnt", nd, 1);
        tally(s + 160, s + 301, nb, nd, nh);
        chk("00_tail_hi", nh, 141);

        // tx_start held: 0x55 then 0xAA back to back.
        din = 8'h55;
        for (int i = 0; i < 16 && s_tick !== 1'b1; i++) step();
        tx_start = 1'b1;
        step();
        s = cyc - 1;
        din = 8'hAA;
        run_to(s + 161);
        tx_start = 1'b0;
        s2 = s + 161;
        run_to(s2 + 175);
        chk("b2b_gap_tx", int'(log_tx[s + 160]), 1);
        chk("b2b_gap_busy", int'(log_busy[s + 160]), 0);
        check_frame("55", s, 10'b1_0101_0101_0, 1);
        check_frame("aa", s2, 10'b1_1010_1010_0, 1);
        tally(s, s2 + 160, nb, nd, nh);
        chk("b2b_idle_clks", (s2 + 160 - s) - nb, 1);
        tally(s, s2 + 171, nb, nd, nh);
        chk("b2b_done_cnt", nd, 2);

        // Reset during data bit 3 of 0xF0 (bit 3 is 0, so the line is low there).
        launch(8'hF0, s);
        run_to(s + 69);
        chk("mid_bit3_low", int'(log_tx[s + 69]), 0);
        rst = 1'b1;
        step();
        chk("mid_rst_tx", int'(log_tx[s + 70]), 1);
        chk("mid_rst_busy", int'(log_busy[s + 70]), 0);
        rst = 1'b0;
        run_to(s + 260);
        tally(s, s + 261, nb, nd, nh);
        chk("mid_rst_done", nd, 0);
        tally(s + 70, s + 261, nb, nd, nh);
        chk("mid_rst_hi", nh, 191);
        launch(8'h81, s2);
        run_to(s2 + 170);
        check_frame("81", s2, 10'b1_1000_0001_0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
